point_frame_buffer: RTL

//   Sits directly downstream of point_formatter. Captures its 128-bit points into a FIFO,

---
 rtl/point_frame_buffer_if.sv | 22 ++
 rtl/point_frame_buffer.sv | 120 ++++++++++++
 2 files changed

// File: rtl/point_frame_buffer_if.sv
// Point capture and output stream signals of point_frame_buffer.
// The slave modport is the buffer; the master modport is the upstream/downstream side.
interface point_frame_buffer_if;
  logic [127:0] point;
  logic         point_valid;
  logic         frame_end;
  logic [127:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         out_err;

  modport slave (
    input  point, point_valid, frame_end, out_ready,
    output out_data, out_valid, out_last, out_err
  );

  modport master (
    output point, point_valid, frame_end, out_ready,
    input  out_data, out_valid, out_last, out_err
  );
endinterface

// File: rtl/point_frame_buffer.sv
// Frame-tagging point FIFO with overflow/MAX_PTS truncation and a guaranteed last beat per frame.
// Optional: define PFB_DROP_COUNTER_EN to add the saturating drop_cnt output.
module point_frame_buffer #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned MAX_PTS = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  point_frame_buffer_if.slave      pfb,
  output logic [15:0]              frame_cnt,
  output logic [$clog2(DEPTH):0]   fifo_level
`ifdef PFB_DROP_COUNTER_EN
  ,
  output logic [15:0]              drop_cnt
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned PW = $clog2(MAX_PTS + 1);
  localparam int unsigned EW = 130;

  typedef enum logic {COLLECT, DISCARD} state_t;

  state_t           state, state_n;
  logic             pending, pending_n;
  logic [PW-1:0]    in_pts, in_pts_n;
  logic [EW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [LW-1:0]    level, level_after_read;
  logic [EW-1:0]    head, wr_entry;
  logic             has_data, rd_en, wr_en, write_point, write_pad;

  assign head             = mem[rd_ptr];
  assign has_data         = (level != '0);
  assign rd_en            = has_data & pfb.out_ready;
  assign level_after_read = level - LW'(rd_en);
  assign wr_en            = write_point | write_pad;

  assign pfb.out_valid = has_data;
  assign pfb.out_data  = has_data ? head[127:0] : '0;
  assign pfb.out_last  = has_data & head[128];
  assign pfb.out_err   = has_data & head[129];
  assign fifo_level    = level;

  always_comb begin
    state_n     = state;
    pending_n   = pending;
    in_pts_n    = in_pts;
    write_point = 1'b0;
    write_pad   = 1'b0;
    wr_entry    = {2'b00, pfb.point};
    if (pending) begin
      if (level_after_read < LW'(DEPTH)) begin
        write_pad = 1'b1;
        wr_entry  = {2'b11, 128'b0};
        pending_n = 1'b0;
        state_n   = COLLECT;
        in_pts_n  = '0;
      end
      // A non-last point lost here starts a frame that is already truncated.
      if (pfb.point_valid && !pfb.frame_end)
        state_n = DISCARD;
    end else if (pfb.point_valid) begin
      if (pfb.frame_end) begin
        in_pts_n = '0;
        state_n  = COLLECT;
        if (level_after_read < LW'(DEPTH)) begin
          write_point = 1'b1;
          wr_entry    = {state == DISCARD, 1'b1, pfb.point};
        end else begin
          pending_n = 1'b1;
        end
      end else if (state == COLLECT && level_after_read < LW'(DEPTH - 1) &&
                   in_pts < PW'(MAX_PTS)) begin
        write_point = 1'b1;
        in_pts_n    = in_pts + PW'(1);
      end else begin
        state_n = DISCARD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= COLLECT;
      pending   <= 1'b0;
      in_pts    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      frame_cnt <= '0;
    end else begin
      state   <= state_n;
      pending <= pending_n;
      in_pts  <= in_pts_n;
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      level     <= level + LW'(wr_en) - LW'(rd_en);
      frame_cnt <= frame_cnt + 16'(rd_en & head[128]);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_entry;
  end

`ifdef PFB_DROP_COUNTER_EN
  logic drop;
  assign drop = pfb.point_valid & ~write_point;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      drop_cnt <= '0;
    else if (drop && drop_cnt != '1)
      drop_cnt <= drop_cnt + 16'd1;
  end
`endif

endmodule
